// File: rtl/playback_ctrl.sv
// Clip playback sequencer: sample-rate divider, ROM address walk, pause/abort.
// Define PLAYBACK_CTRL_LOOP_EN to honour cmd_loops (clip repeats).
module playback_ctrl #(
    parameter int CLOCK_RATE  = 3_125_000,
    parameter int SAMPLE_RATE = 16_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [13:0] cmd_start,
    input  logic [13:0] cmd_len,
    input  logic [3:0]  cmd_loops,
    input  logic        pause,
    input  logic        abort,
    output logic [13:0] rom_addr,
    output logic        sample_tick,
    output logic        playing,
    output logic        done,
    output logic [1:0]  state
);

    localparam int DIVIDER = CLOCK_RATE / SAMPLE_RATE;
    localparam int CW      = $clog2(DIVIDER);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIVIDER - 1);

`ifdef PLAYBACK_CTRL_LOOP_EN
    localparam logic LOOP_EN = 1'b1;
`else
    localparam logic LOOP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [13:0]   rom_addr_q, rom_addr_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [13:0]   remaining_q, remaining_d;
    logic [3:0]    loops_left_q, loops_left_d;
    logic [13:0]   clip_start_q, clip_start_d;
    logic [13:0]   clip_last_q, clip_last_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;

    logic run;
    logic wrap;
    logic last;

    assign wrap = (div_cnt_q == DIV_LAST);
    // Final divider period of the final pass: completion outranks pause.
    assign last = wrap && (remaining_q == 14'd0) && (loops_left_q == 4'd0);

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        div_cnt_d    = div_cnt_q;
        remaining_d  = remaining_q;
        loops_left_d = loops_left_q;
        clip_start_d = clip_start_q;
        clip_last_d  = clip_last_q;
        tick_d       = 1'b0;
        done_d       = 1'b0;
        run          = 1'b0;
        cmd_ready    = enable && (state_q == IDLE);

        if (enable) begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len == 14'd0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d      = PLAY;
                            rom_addr_d   = cmd_start;
                            div_cnt_d    = '0;
                            remaining_d  = cmd_len - 14'd1;
                            loops_left_d = cmd_loops & {4{LOOP_EN}};
                            clip_start_d = cmd_start;
                            clip_last_d  = cmd_len - 14'd1;
                        end
                    end
                end
                PLAY: begin
                    if (abort) begin
                        state_d = IDLE;
                    end else if (pause && !last) begin
                        state_d = PAUSE;
                    end else begin
                        run = 1'b1;
                    end
                end
                PAUSE: begin
                    if (abort) begin
                        state_d = IDLE;
                    end else if (!pause) begin
                        // Resume counts this cycle so a pause costs its length.
                        state_d = PLAY;
                        run     = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (run) begin
                if (!wrap) begin
                    div_cnt_d = div_cnt_q + CW'(1);
                end else begin
                    div_cnt_d = '0;
                    if (remaining_q != 14'd0) begin
                        rom_addr_d  = rom_addr_q + 14'd1;
                        remaining_d = remaining_q - 14'd1;
                        tick_d      = 1'b1;
                    end else if (loops_left_q != 4'd0) begin
                        rom_addr_d   = clip_start_q;
                        remaining_d  = clip_last_q;
                        loops_left_d = loops_left_q - 4'd1;
                        tick_d       = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rom_addr_q   <= '0;
            div_cnt_q    <= '0;
            remaining_q  <= '0;
            loops_left_q <= '0;
            clip_start_q <= '0;
            clip_last_q  <= '0;
            tick_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            div_cnt_q    <= div_cnt_d;
            remaining_q  <= remaining_d;
            loops_left_q <= loops_left_d;
            clip_start_q <= clip_start_d;
            clip_last_q  <= clip_last_d;
            tick_q       <= tick_d;
            done_q       <= done_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign sample_tick = tick_q;
    assign done        = done_q;
    assign playing     = (state_q != IDLE);
    assign state       = state_q;

endmodule

// File: tb/tb_playback_ctrl.sv
// Scoreboarded bench for playback_ctrl against a progress-based clip model.
module tb_playback_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [13:0] cmd_start = '0;
    logic [13:0] cmd_len = '0;
    logic [3:0]  cmd_loops = '0;
    logic        pause = 1'b0;
    logic        abort = 1'b0;
    logic        cmd_ready;
    logic [13:0] rom_addr;
    logic        sample_tick;
    logic        playing;
    logic        done;
    logic [1:0]  state;

    playback_ctrl #(.CLOCK_RATE(40), .SAMPLE_RATE(10)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_loops(cmd_loops),
        .pause(pause), .abort(abort), .rom_addr(rom_addr),
        .sample_tick(sample_tick), .playing(playing), .done(done),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [13:0] addr;
        int          at;
    } ev_t;

    ev_t evq[$];
    ev_t mev;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    // Model: a clip is a timeline of total = len*DIV*passes productive cycles.
    bit          m_active = 1'b0;
    bit          m_paused = 1'b0;
    int          m_p = 0;
    int          m_total = 0;
    int          m_len = 0;
    logic [13:0] m_start = '0;
    logic [13:0] m_addr = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input bit d, input logic [13:0] a);
        ev_t e;
        e.is_done = d;
        e.addr = a;
        e.at = cyc;
        evq.push_back(e);
    endtask

    task automatic advance();
        m_p++;
        if (m_p == m_total) begin
            m_active = 1'b0;
            push_ev(1'b1, m_addr);
        end else if (m_p % DIV == 0) begin
            m_addr = 14'((int'(m_start) + (m_p / DIV) % m_len) % 16384);
            push_ev(1'b0, m_addr);
        end
    endtask

    task automatic step();
        bit en, v, pz, ab;
        logic [13:0] s, l;
        logic [3:0] lp;
        int passes;
        en = enable; v = cmd_valid; pz = pause; ab = abort;
        s = cmd_start; l = cmd_len; lp = cmd_loops;
        @(posedge clk);
        cyc++;
        if (en && rst_n) begin
            if (!m_active) begin
                if (v) begin
`ifdef PLAYBACK_CTRL_LOOP_EN
                    passes = int'(lp) + 1;
`else
                    passes = 1;
                    lp = lp;
`endif
                    if (l == 14'd0) begin
                        push_ev(1'b1, m_addr);
                    end else begin
                        m_active = 1'b1;
                        m_paused = 1'b0;
                        m_p = 0;
                        m_len = int'(l);
                        m_start = s;
                        m_addr = s;
                        m_total = m_len * DIV * passes;
                    end
                end
            end else if (ab) begin
                m_active = 1'b0;
            end else if (m_paused) begin
                if (!pz) begin
                    m_paused = 1'b0;
                    advance();
                end
            end else if (pz && (m_p + 1 != m_total)) begin
                m_paused = 1'b1;
            end else begin
                advance();
            end
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [13:0] s, input logic [13:0] l,
                        input logic [3:0] lp);
        cmd_valid = 1'b1;
        cmd_start = s;
        cmd_len = l;
        cmd_loops = lp;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic run_idle(input int max);
        for (int i = 0; i < max && m_active; i++) step();
        chk("idle_timeout", {31'b0, m_active}, 32'd0);
        step();
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            while (evq.size() > 0 && evq[0].at < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_event: got none want done=%0d addr=%0d at %0d",
                         evq[0].is_done, evq[0].addr, evq[0].at);
                void'(evq.pop_front());
            end
            if (sample_tick || done) begin
                if (evq.size() == 0) begin
                    chk("unexpected_event", {30'b0, sample_tick, done}, 32'd0);
                end else begin
                    mev = evq.pop_front();
                    chk("event_done", {31'b0, done}, {31'b0, mev.is_done});
                    chk("event_tick", {31'b0, sample_tick}, {31'b0, !mev.is_done});
                    chk("event_cycle", cyc, mev.at);
                    if (!mev.is_done) chk("tick_addr", {18'b0, rom_addr}, {18'b0, mev.addr});
                end
            end
            chk("rom_addr", {18'b0, rom_addr}, {18'b0, m_addr});
            chk("state", {30'b0, state},
                !m_active ? 32'd0 : (m_paused ? 32'd2 : 32'd1));
            chk("playing", {31'b0, playing}, {31'b0, m_active});
            chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, enable && !m_active});
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #20;
        chk("rst_rom_addr", {18'b0, rom_addr}, 32'd0);
        chk("rst_tick", {31'b0, sample_tick}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_playing", {31'b0, playing}, 32'd0);
        chk("rst_state", {30'b0, state}, 32'd0);
        chk("rst_ready_dis", {31'b0, cmd_ready}, 32'd0);
        enable = 1'b1;
        #1;
        chk("rst_ready_en", {31'b0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_on = 1'b1;

        send(14'd100, 14'd3, 4'd0);
        run_idle(40);
        send(14'd16382, 14'd4, 4'd0);
        run_idle(40);
        send(14'd10, 14'd2, 4'd2);
        run_idle(60);

        send(14'd200, 14'd3, 4'd0);
        steps(5);
        pause = 1'b1;
        steps(10);
        pause = 1'b0;
        run_idle(60);

        send(14'd300, 14'd5, 4'd0);
        steps(3);
        pause = 1'b1;
        steps(3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        pause = 1'b0;
        steps(4);

        send(14'd5, 14'd0, 4'd0);
        steps(2);

        send(14'd500, 14'd1, 4'd0);
        steps(3);
        pause = 1'b1;
        step();
        pause = 1'b0;
        steps(2);

        send(14'd400, 14'd3, 4'd0);
        steps(3);
        enable = 1'b0;
        steps(5);
        enable = 1'b1;
        run_idle(40);

        abort = 1'b1;
        step();
        abort = 1'b0;
        send(14'd600, 14'd2, 4'd0);
        steps(2);
        abort = 1'b1;
        pause = 1'b1;
        step();
        abort = 1'b0;
        pause = 1'b0;
        steps(2);

        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 19) != 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_start = ($urandom_range(0, 3) == 0) ?
                        14'(16380 + $urandom_range(0, 3)) : 14'($urandom);
            cmd_len = 14'($urandom_range(0, 5));
            cmd_loops = 4'($urandom_range(0, 3));
            pause = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 59) == 0);
            step();
        end
        enable = 1'b1;
        cmd_valid = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        run_idle(500);

        send(14'd700, 14'd4, 4'd0);
        steps(6);
        #2;
        rst_n = 1'b0;
        mon_on = 1'b0;
        #1;
        chk("arst_rom_addr", {18'b0, rom_addr}, 32'd0);
        chk("arst_state", {30'b0, state}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_tick", {31'b0, sample_tick}, 32'd0);
        m_active = 1'b0;
        m_paused = 1'b0;
        m_addr = '0;
        evq.delete();
        #1;
        steps(2);
        chk("arst_hold_done", {31'b0, done}, 32'd0);
        #2 rst_n = 1'b1;
        step();
        mon_on = 1'b1;
        send(14'd42, 14'd2, 4'd0);
        run_idle(40);
        steps(2);

        chk("queue_drained", evq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
